// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default baud divisor and line levels
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: level handshake and serial line between sample controller and uart_tx
interface uart_tx_if;
  logic       Tx_en;
  logic [7:0] Tx_Byte;
  logic       Tx_Ready_To_Send;
  logic       Tx_Serial;
  logic       Tx_Done;
  modport master (output Tx_en, Tx_Byte, input Tx_Ready_To_Send, Tx_Serial, Tx_Done);
  modport slave (input Tx_en, Tx_Byte, output Tx_Ready_To_Send, Tx_Serial, Tx_Done);
endinterface

// File: rtl/uart_tx_baud_tick.sv
// baud_tick: bit-period counter emitting a one-cycle tick on the last clock of each bit
module baud_tick import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == LAST);
  // count 0..CLKS_PER_BIT-1, restarting exactly on each bit boundary so timing never drifts
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser, one byte per Tx_en request, LSB first, registered outputs
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input logic   clk,
  input logic   reset_b,
  uart_tx_if.slave bus
);
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be 2..65535");
  end
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  tx_state_t  r_state, w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_idx, w_idx_nxt;
  logic       r_serial, r_rts, r_done;
  logic       w_tick, w_idle, w_serial_nxt;
  assign w_idle = (r_state == IDLE);
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset_b(reset_b),
    .i_clr  (w_idle),
    .i_en   (!w_idle),
    .o_tick (w_tick)
  );
  // next state and bit index; the line level is derived from the next state so it can be registered
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE:  if (bus.Tx_en) w_state_nxt = START;
      START: if (w_tick) begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
      end
      DATA:  if (w_tick) begin
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == 3'd7) w_state_nxt = STOP;
      end
      STOP:  if (w_tick) begin
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == LAST_STOP) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_serial_nxt = (w_state_nxt == START) ? START_BIT :
                   (w_state_nxt == DATA)  ? r_shift[w_idx_nxt] : LINE_IDLE;
  end
  // state, byte capture and glitch-free registered outputs; reset drops any frame in flight
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_shift  <= '0;
      r_serial <= LINE_IDLE;
      r_rts    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_serial <= w_serial_nxt;
      r_rts    <= (w_state_nxt == IDLE);
      r_done   <= (r_state == STOP) && (w_state_nxt == IDLE);
      if (w_idle && bus.Tx_en) r_shift <= bus.Tx_Byte;
    end
  assign bus.Tx_Serial        = r_serial;
  assign bus.Tx_Ready_To_Send = r_rts;
  assign bus.Tx_Done          = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames with a queue scoreboard and a frame-decoding monitor per DUT
module tb_uart_tx;
  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;
  logic clk, reset_b;
  int checks = 0, errors = 0;
  exp_t qa[$], qb[$];
  uart_tx_if ifa();
  uart_tx_if ifb();
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (.clk(clk), .reset_b(reset_b), .bus(ifa));
  uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (.clk(clk), .reset_b(reset_b), .bus(ifb));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic get_ser(input int s);
    return s != 0 ? ifb.Tx_Serial : ifa.Tx_Serial;
  endfunction
  function automatic logic get_rts(input int s);
    return s != 0 ? ifb.Tx_Ready_To_Send : ifa.Tx_Ready_To_Send;
  endfunction
  function automatic logic get_done(input int s);
    return s != 0 ? ifb.Tx_Done : ifa.Tx_Done;
  endfunction
  function automatic int qsize(input int s);
    return s != 0 ? qb.size() : qa.size();
  endfunction

  task automatic push(input int s, input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap = gap;
    if (s != 0) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic drive(input int s, input logic en, input logic [7:0] b);
    if (s != 0) begin
      ifb.Tx_en = en;
      ifb.Tx_Byte = b;
    end else begin
      ifa.Tx_en = en;
      ifa.Tx_Byte = b;
    end
  endtask

  task automatic send(input int s, input logic [7:0] b, input int hold);
    @(posedge clk);
    #1 drive(s, 1'b1, b);
    repeat (hold) @(posedge clk);
    #1 drive(s, 1'b0, b);
  endtask

  task automatic wait_done(input int s);
    int t;
    t = 0;
    while ((qsize(s) != 0 || !get_rts(s)) && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", int'(t < 500), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic monitor(input int s, input int cpb, input int ns);
    logic lv[64];
    logic [7:0] d;
    exp_t e;
    int n, idle, nbusy, ndone, bad, stops;
    bit first, prev, ab;
    n = (9 + ns) * cpb;
    idle = 0;
    first = 1;
    prev = 1;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        prev = 1;
        first = 1;
        idle = 0;
      end else if (get_rts(s)) begin
        prev = 1;
        idle++;
        chk("done_while_idle", int'(get_done(s)), 0);
      end else if (prev) begin
        nbusy = 0;
        ndone = 0;
        ab = 0;
        for (int c = 0; c < n; c++) begin
          if (c > 0) @(negedge clk);
          if (!reset_b) begin
            ab = 1;
            break;
          end
          lv[c] = get_ser(s);
          nbusy += int'(!get_rts(s));
          ndone += int'(get_done(s));
        end
        if (ab) begin
          prev = 1;
          first = 1;
          idle = 0;
        end else begin
          @(negedge clk);
          chk("end_ready", int'(get_rts(s)), 1);
          chk("end_done", int'(get_done(s)), 1);
          bad = 0;
          stops = 0;
          for (int b = 0; b < 9 + ns; b++)
            for (int k = 1; k < cpb; k++)
              if (lv[b*cpb+k] !== lv[b*cpb]) bad++;
          for (int i = 0; i < 8; i++) d[i] = lv[(i+1)*cpb];
          for (int b = 9; b < 9 + ns; b++) stops += int'(lv[b*cpb] === 1'b1);
          chk("bit_hold", bad, 0);
          chk("start_bit", int'(lv[0]), 0);
          chk("stop_bits", stops, ns);
          chk("busy_cycles", nbusy, n);
          chk("done_in_frame", ndone, 0);
          chk("frame_expected", int'(qsize(s) > 0), 1);
          if (qsize(s) > 0) begin
            e = (s != 0) ? qb.pop_front() : qa.pop_front();
            chk("byte", int'(d), int'(e.data));
            if (e.gap >= 0 && !first) chk("gap", idle, e.gap);
          end
          prev = 1;
          idle = 1;
          first = 0;
        end
      end
    end
  endtask

  initial monitor(0, 4, 1);
  initial monitor(1, 3, 2);

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    reset_b = 1;
    #2 reset_b = 0;
    #1;
    chk("rst_a_line", int'(ifa.Tx_Serial), 1);
    chk("rst_a_ready", int'(ifa.Tx_Ready_To_Send), 1);
    chk("rst_a_done", int'(ifa.Tx_Done), 0);
    chk("rst_b_line", int'(ifb.Tx_Serial), 1);
    chk("rst_b_ready", int'(ifb.Tx_Ready_To_Send), 1);
    repeat (2) @(posedge clk);
    #3 reset_b = 1;
    send(0, 8'h00, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_line", int'(ifa.Tx_Serial), 0);
    chk("pre_reset_ready", int'(ifa.Tx_Ready_To_Send), 0);
    #1 reset_b = 0;
    #1;
    chk("abort_line", int'(ifa.Tx_Serial), 1);
    chk("abort_ready", int'(ifa.Tx_Ready_To_Send), 1);
    chk("abort_done", int'(ifa.Tx_Done), 0);
    repeat (2) @(posedge clk);
    #3 reset_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_ready", int'(ifa.Tx_Ready_To_Send), 1);
    chk("post_reset_line", int'(ifa.Tx_Serial), 1);
    push(0, 8'hA5, -1);
    send(0, 8'hA5, 1);
    wait_done(0);
    push(0, 8'h3C, -1);
    send(0, 8'h3C, 2);
    wait_done(0);
    repeat (45) @(posedge clk);
    #1 chk("single_frame_ready", int'(ifa.Tx_Ready_To_Send), 1);
    push(0, 8'hAB, -1);
    push(0, 8'h12, 1);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'hAB);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'h12);
    begin
      int t;
      t = 0;
      do begin
        @(posedge clk);
        #1 t++;
      end while (!ifa.Tx_Ready_To_Send && t < 100);
      chk("ready_rise_timeout", int'(t < 100), 1);
    end
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h12);
    wait_done(0);
    push(0, 8'h00, -1);
    send(0, 8'h00, 1);
    ifa.Tx_Byte = 8'hFF;
    wait_done(0);
    push(1, 8'h80, -1);
    send(1, 8'h80, 1);
    wait_done(1);
    chk("queues_empty", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART serialiser downstream of the pool-test sample controller.
- Accepts one byte per Tx_en request (LSB byte, then MSB byte of each hydrophone sample) and shifts it out LSB-first on Tx_Serial.
- Reports idle/busy on Tx_Ready_To_Send.
- Its level-based handshake matches the controller's ENABLE/SEND states: Tx_en is held until Tx_Ready_To_Send drops.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; 1 or 2 only.

Ports:
- clk  input  1  system clock, single clock domain.
- reset_b  input  1  asynchronous, active-low reset.
- Tx_en  input  1  transmit request (level); sampled only while idle.
- Tx_Byte  input  8  byte to send; captured on the accepting edge.
- Tx_Ready_To_Send  output  1  high = idle and able to accept; low = frame in progress.
- Tx_Serial  output  1  UART line; idle high.
- Tx_Done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async, reset_b low), applied immediately and independent of clk:
  - state=IDLE, Tx_Serial=1, Tx_Ready_To_Send=1, Tx_Done=0.
  - Baud counter and bit index are cleared; the shift register is cleared.
- Mid-frame reset aborts the frame: the line returns high at once, with no partial stop bit.
- State machine (registered) with states IDLE, START, DATA, STOP:
  - IDLE:
    - Tx_Serial=1, Tx_Ready_To_Send=1.
    - On a clk edge with Tx_en=1: latch Tx_Byte into the shift register, clear the baud counter, go to START.
  - START: Tx_Serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - Tx_Serial = shift register bit[index], each bit held for CLKS_PER_BIT cycles, index 0..7.
    - After bit 7, go to STOP.
  - STOP: Tx_Serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE and assert Tx_Done for exactly that one cycle.
- Timing:
  - Tx_Ready_To_Send is registered.
  - It goes low in the cycle after the accepting edge, i.e. the same cycle Tx_Serial first drives 0.
  - It stays low until IDLE is re-entered.
  - Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles from the accepting edge to the return to IDLE.
- Outputs are registered, so Tx_Serial is glitch-free.
- Tx_en while busy is ignored, including the controller's second Tx_en cycle during which Tx_Ready_To_Send has already dropped. There is no queueing.
- Tx_Byte changes after the accepting edge have no effect on the frame in flight.
- Back-to-back frames: if Tx_en=1 on the first IDLE cycle after STOP, the next frame is accepted on that edge. The minimum inter-frame idle time is 1 cycle.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary; there is no cumulative drift.
- Illegal STOP_BITS (not 1 or 2) is rejected at elaboration.

Decomposition:
- Shared package (uart_pkg):
  - tx state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
  - DEFAULT_CLKS_PER_BIT=434.
  - Line levels LINE_IDLE=1, START_BIT=0.
- One sub-module, baud_tick:
  - Parameterised counter with clear and enable inputs.
  - Emits a one-cycle tick at count CLKS_PER_BIT-1.
  - The future uart_rx reuses it.

Test Plan:
1. Reset (CLKS_PER_BIT=4): assert reset_b=0 mid-DATA -> Tx_Serial=1 and Tx_Ready_To_Send=1 without waiting for a clk edge; after release, the block sits in IDLE.
2. Tx_Byte=0xA5, Tx_en pulse (CLKS_PER_BIT=4) -> line shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; Tx_Ready_To_Send low for 40 cycles; Tx_Done high for exactly 1 cycle.
3. Controller-style handshake: hold Tx_en=1 until Tx_Ready_To_Send falls (2 cycles) -> exactly one frame sent; the second high cycle is ignored.
4. Sample 0x12AB sent as byte 0xAB then 0x12, with Tx_en re-asserted on the first IDLE cycle -> two contiguous frames; decoded bytes AB, 12; 1 idle-high cycle between them.
5. Change Tx_Byte to 0xFF one cycle after acceptance of 0x00 -> the line carries 0x00 (all data bits 0).
6. STOP_BITS=2, CLKS_PER_BIT=3, byte 0x80 -> stop level held 6 cycles; total busy time 33 cycles.
